// File: rtl/lsu_axi_wr_arb.sv
// rtl/lsu_axi_wr_arb.sv - round-robin arbiter sharing the LSU AXI write port between store requesters
//
// Grants one requester at a time and holds the grant from the address handshake to
// the last counted write-data beat. Every accepted request leaves a tag {requester,
// extra-response count} in an in-order FIFO, and write responses are steered to the
// requester that owns the oldest tag.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_aw*/req_awrdy        per-requester address request (fields packed per requester)
//   req_w*/req_wrdy          per-requester write data
//   req_bvld/req_brdy        per-requester response handshake
//   req_bresp, req_resp_oram_addr  response payload shared by all requesters
//   lsu_axi_aw*/axi_lsu_awrdy  address channel to the write interface
//   lsu_axi_w*/axi_lsu_wrdy    data channel to the write interface
//   axi_lsu_b*/lsu_axi_brdy    response channel from the write interface
//   arb_busy                 FSM active or responses still outstanding
//   err_wlast, err_orphan_b  sticky protocol error flags
module lsu_axi_wr_arb #(
  parameter int NREQ      = 2,
  parameter int OST_DEPTH = 4,
  parameter int RIDX_W    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_awvld,
  input  logic [NREQ*10-1:0]   req_awaddr,
  input  logic [NREQ*8-1:0]    req_awlen,
  input  logic [NREQ*3-1:0]    req_awsize,
  input  logic [NREQ*2-1:0]    req_awburst,
  input  logic [NREQ*3-1:0]    req_awstr,
  input  logic [NREQ*8-1:0]    req_awnum,
  input  logic [NREQ*13-1:0]   req_oram_addr,
  output logic [NREQ-1:0]      req_awrdy,
  input  logic [NREQ-1:0]      req_wvld,
  input  logic [NREQ*64-1:0]   req_wdata,
  input  logic [NREQ*8-1:0]    req_wstrb,
  input  logic [NREQ-1:0]      req_wlast,
  output logic [NREQ-1:0]      req_wrdy,
  output logic [NREQ-1:0]      req_bvld,
  input  logic [NREQ-1:0]      req_brdy,
  output logic [1:0]           req_bresp,
  output logic [12:0]          req_resp_oram_addr,
  output logic                 lsu_axi_awvld,
  output logic [9:0]           lsu_axi_awaddr,
  output logic [7:0]           lsu_axi_awlen,
  output logic [2:0]           lsu_axi_awsize,
  output logic [1:0]           lsu_axi_awburst,
  output logic [2:0]           lsu_axi_awstr,
  output logic [7:0]           lsu_axi_awnum,
  output logic [12:0]          lsu_axi_oram_addr,
  input  logic                 axi_lsu_awrdy,
  output logic                 lsu_axi_wvld,
  output logic [63:0]          lsu_axi_wdata,
  output logic [7:0]           lsu_axi_wstrb,
  output logic                 lsu_axi_wlast,
  input  logic                 axi_lsu_wrdy,
  input  logic                 axi_lsu_bvld,
  input  logic [1:0]           axi_lsu_bresp,
  input  logic [12:0]          axi_lsu_resp_oram_addr,
  output logic                 lsu_axi_brdy,
  output logic                 arb_busy,
  output logic                 err_wlast,
  output logic                 err_orphan_b
);

  localparam int PTR_W = $clog2(OST_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [RIDX_W-1:0] grant_q, grant_d;
  logic [RIDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [RIDX_W-1:0] pick;
  logic [12:0]       beats_total_q, beats_total_d;
  logic [12:0]       beat_cnt_q, beat_cnt_d;
  logic              err_wlast_q, err_wlast_d;
  logic              err_orphan_q, err_orphan_d;

  logic [RIDX_W-1:0] tag_g_q [OST_DEPTH];
  logic [RIDX_W-1:0] tag_g_d [OST_DEPTH];
  logic [3:0]        tag_n_q [OST_DEPTH];
  logic [3:0]        tag_n_d [OST_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              fifo_empty, fifo_full;
  logic              push, pop, dec;
  logic [RIDX_W-1:0] head_g;
  logic [3:0]        head_n;
  logic              final_beat;

  logic [9:0]  aw_addr_a  [NREQ];
  logic [7:0]  aw_len_a   [NREQ];
  logic [2:0]  aw_size_a  [NREQ];
  logic [1:0]  aw_burst_a [NREQ];
  logic [2:0]  aw_str_a   [NREQ];
  logic [7:0]  aw_num_a   [NREQ];
  logic [12:0] aw_oram_a  [NREQ];
  logic [63:0] w_data_a   [NREQ];
  logic [7:0]  w_strb_a   [NREQ];

  // Unpack the flat per-requester buses so the grant index can select whole fields.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      aw_addr_a[i]  = req_awaddr[i*10 +: 10];
      aw_len_a[i]   = req_awlen[i*8 +: 8];
      aw_size_a[i]  = req_awsize[i*3 +: 3];
      aw_burst_a[i] = req_awburst[i*2 +: 2];
      aw_str_a[i]   = req_awstr[i*3 +: 3];
      aw_num_a[i]   = req_awnum[i*8 +: 8];
      aw_oram_a[i]  = req_oram_addr[i*13 +: 13];
      w_data_a[i]   = req_wdata[i*64 +: 64];
      w_strb_a[i]   = req_wstrb[i*8 +: 8];
    end
  end

  // Circular priority search: scanning from the farthest offset down to rr_ptr
  // lets the closest requester at or after rr_ptr win.
  always_comb begin
    pick = rr_ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_awvld[(int'(rr_ptr_q) + k) % NREQ]) begin
        pick = RIDX_W'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(OST_DEPTH));
  assign head_g     = tag_g_q[rd_ptr_q];
  assign head_n     = tag_n_q[rd_ptr_q];
  assign final_beat = (beat_cnt_q == beats_total_q - 13'd1);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    beats_total_d = beats_total_q;
    beat_cnt_d    = beat_cnt_q;
    err_wlast_d   = err_wlast_q;
    err_orphan_d  = err_orphan_q | (axi_lsu_bvld & fifo_empty);
    push          = 1'b0;
    pop           = 1'b0;
    dec           = 1'b0;

    req_awrdy          = '0;
    req_wrdy           = '0;
    req_bvld           = '0;
    lsu_axi_awvld      = 1'b0;
    lsu_axi_awaddr     = '0;
    lsu_axi_awlen      = '0;
    lsu_axi_awsize     = '0;
    lsu_axi_awburst    = '0;
    lsu_axi_awstr      = '0;
    lsu_axi_awnum      = '0;
    lsu_axi_oram_addr  = '0;
    lsu_axi_wvld       = 1'b0;
    lsu_axi_wdata      = '0;
    lsu_axi_wstrb      = '0;
    lsu_axi_wlast      = 1'b0;
    lsu_axi_brdy       = 1'b0;
    req_bresp          = axi_lsu_bresp;
    req_resp_oram_addr = axi_lsu_resp_oram_addr;

    case (state_q)
      S_IDLE: begin
        if ((|req_awvld) && !fifo_full) begin
          grant_d = pick;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        lsu_axi_awvld      = req_awvld[grant_q];
        lsu_axi_awaddr     = aw_addr_a[grant_q];
        lsu_axi_awlen      = aw_len_a[grant_q];
        lsu_axi_awsize     = aw_size_a[grant_q];
        lsu_axi_awburst    = aw_burst_a[grant_q];
        lsu_axi_awstr      = aw_str_a[grant_q];
        lsu_axi_awnum      = aw_num_a[grant_q];
        lsu_axi_oram_addr  = aw_oram_a[grant_q];
        req_awrdy[grant_q] = axi_lsu_awrdy;
        if (!req_awvld[grant_q]) begin
          // Requester withdrew before acceptance: nothing was promised downstream.
          state_d = S_IDLE;
        end else if (axi_lsu_awrdy) begin
          // One request carries awnum[3:0]+1 strided bursts of awlen+1 beats each.
          beats_total_d = (13'(aw_num_a[grant_q][3:0]) + 13'd1) * (13'(aw_len_a[grant_q]) + 13'd1);
          beat_cnt_d    = '0;
          push          = 1'b1;
          state_d       = S_DATA;
        end
      end
      S_DATA: begin
        lsu_axi_wvld      = req_wvld[grant_q];
        lsu_axi_wdata     = w_data_a[grant_q];
        lsu_axi_wstrb     = w_strb_a[grant_q];
        lsu_axi_wlast     = req_wlast[grant_q];
        req_wrdy[grant_q] = axi_lsu_wrdy;
        if (req_wvld[grant_q] && axi_lsu_wrdy) begin
          beat_cnt_d = beat_cnt_q + 13'd1;
          // The beat count alone ends the request; wlast is only cross-checked.
          if (final_beat != req_wlast[grant_q]) begin
            err_wlast_d = 1'b1;
          end
          if (final_beat) begin
            state_d  = S_IDLE;
            rr_ptr_d = (grant_q == RIDX_W'(NREQ - 1)) ? '0 : grant_q + RIDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!fifo_empty) begin
      req_bvld[head_g] = axi_lsu_bvld;
      lsu_axi_brdy     = req_brdy[head_g];
      if (axi_lsu_bvld && req_brdy[head_g]) begin
        // Each strided burst returns its own response; the tag retires on the last.
        if (head_n == 4'd0) begin
          pop = 1'b1;
        end else begin
          dec = 1'b1;
        end
      end
    end
  end

  // A push never targets the head entry while it is being decremented: the grant
  // was only made with a free slot, so a non-empty FIFO has wr_ptr != rd_ptr.
  always_comb begin
    tag_g_d  = tag_g_q;
    tag_n_d  = tag_n_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      tag_g_d[wr_ptr_q] = grant_q;
      tag_n_d[wr_ptr_q] = aw_num_a[grant_q][3:0];
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    if (dec) begin
      tag_n_d[rd_ptr_q] = head_n - 4'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      beats_total_q <= '0;
      beat_cnt_q    <= '0;
      err_wlast_q   <= 1'b0;
      err_orphan_q  <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < OST_DEPTH; i++) begin
        tag_g_q[i] <= '0;
        tag_n_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      beats_total_q <= beats_total_d;
      beat_cnt_q    <= beat_cnt_d;
      err_wlast_q   <= err_wlast_d;
      err_orphan_q  <= err_orphan_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      tag_g_q       <= tag_g_d;
      tag_n_q       <= tag_n_d;
    end
  end

  assign arb_busy     = (state_q != S_IDLE) | ~fifo_empty;
  assign err_wlast    = err_wlast_q;
  assign err_orphan_b = err_orphan_q;

endmodule

// File: tb/tb_lsu_axi_wr_arb.sv
// tb/tb_lsu_axi_wr_arb.sv - scoreboard bench for lsu_axi_wr_arb
module tb_lsu_axi_wr_arb;
  localparam int NREQ      = 2;
  localparam int OST_DEPTH = 4;
  localparam int RIDX_W    = 1;

  typedef struct {
    int          g;
    logic [9:0]  addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [2:0]  str;
    logic [7:0]  num;
    logic [12:0] oram;
  } aw_t;

  typedef struct {
    int          g;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_awvld, req_awrdy, req_wvld, req_wlast, req_wrdy, req_bvld, req_brdy;
  logic [NREQ*10-1:0] req_awaddr;
  logic [NREQ*8-1:0]  req_awlen, req_awnum, req_wstrb;
  logic [NREQ*3-1:0]  req_awsize, req_awstr;
  logic [NREQ*2-1:0]  req_awburst;
  logic [NREQ*13-1:0] req_oram_addr;
  logic [NREQ*64-1:0] req_wdata;
  logic [1:0]  req_bresp, lsu_axi_awburst, axi_lsu_bresp;
  logic [12:0] req_resp_oram_addr, lsu_axi_oram_addr, axi_lsu_resp_oram_addr;
  logic        lsu_axi_awvld, lsu_axi_wvld, lsu_axi_wlast, lsu_axi_brdy;
  logic [9:0]  lsu_axi_awaddr;
  logic [7:0]  lsu_axi_awlen, lsu_axi_awnum, lsu_axi_wstrb;
  logic [2:0]  lsu_axi_awsize, lsu_axi_awstr;
  logic [63:0] lsu_axi_wdata;
  logic        axi_lsu_awrdy = 1'b0, axi_lsu_wrdy = 1'b0, axi_lsu_bvld = 1'b0;
  logic        arb_busy, err_wlast, err_orphan_b;

  logic awvld_r [NREQ];
  aw_t  aw_r    [NREQ];
  logic wvld_r  [NREQ];
  w_t   w_r     [NREQ];
  logic brdy_r  [NREQ];

  always_comb begin
    req_awvld = '0; req_awaddr = '0; req_awlen = '0; req_awsize = '0; req_awburst = '0;
    req_awstr = '0; req_awnum = '0; req_oram_addr = '0; req_wvld = '0; req_wdata = '0;
    req_wstrb = '0; req_wlast = '0; req_brdy = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_awvld[i]             = awvld_r[i];
      req_awaddr[i*10 +: 10]   = aw_r[i].addr;
      req_awlen[i*8 +: 8]      = aw_r[i].len;
      req_awsize[i*3 +: 3]     = aw_r[i].size;
      req_awburst[i*2 +: 2]    = aw_r[i].burst;
      req_awstr[i*3 +: 3]      = aw_r[i].str;
      req_awnum[i*8 +: 8]      = aw_r[i].num;
      req_oram_addr[i*13 +: 13] = aw_r[i].oram;
      req_wvld[i]              = wvld_r[i];
      req_wdata[i*64 +: 64]    = w_r[i].data;
      req_wstrb[i*8 +: 8]      = w_r[i].strb;
      req_wlast[i]             = w_r[i].last;
      req_brdy[i]              = brdy_r[i];
    end
  end

  lsu_axi_wr_arb #(.NREQ(NREQ), .OST_DEPTH(OST_DEPTH), .RIDX_W(RIDX_W)) dut (
    .clk(clk), .rst(rst),
    .req_awvld(req_awvld), .req_awaddr(req_awaddr), .req_awlen(req_awlen),
    .req_awsize(req_awsize), .req_awburst(req_awburst), .req_awstr(req_awstr),
    .req_awnum(req_awnum), .req_oram_addr(req_oram_addr), .req_awrdy(req_awrdy),
    .req_wvld(req_wvld), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_wlast(req_wlast), .req_wrdy(req_wrdy),
    .req_bvld(req_bvld), .req_brdy(req_brdy), .req_bresp(req_bresp),
    .req_resp_oram_addr(req_resp_oram_addr),
    .lsu_axi_awvld(lsu_axi_awvld), .lsu_axi_awaddr(lsu_axi_awaddr), .lsu_axi_awlen(lsu_axi_awlen),
    .lsu_axi_awsize(lsu_axi_awsize), .lsu_axi_awburst(lsu_axi_awburst), .lsu_axi_awstr(lsu_axi_awstr),
    .lsu_axi_awnum(lsu_axi_awnum), .lsu_axi_oram_addr(lsu_axi_oram_addr), .axi_lsu_awrdy(axi_lsu_awrdy),
    .lsu_axi_wvld(lsu_axi_wvld), .lsu_axi_wdata(lsu_axi_wdata), .lsu_axi_wstrb(lsu_axi_wstrb),
    .lsu_axi_wlast(lsu_axi_wlast), .axi_lsu_wrdy(axi_lsu_wrdy),
    .axi_lsu_bvld(axi_lsu_bvld), .axi_lsu_bresp(axi_lsu_bresp),
    .axi_lsu_resp_oram_addr(axi_lsu_resp_oram_addr), .lsu_axi_brdy(lsu_axi_brdy),
    .arb_busy(arb_busy), .err_wlast(err_wlast), .err_orphan_b(err_orphan_b)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  int   m_rr = 0;
  logic m_err_wlast = 1'b0;
  bit   abort = 1'b0;
  aw_t  exp_aw [$];
  w_t   exp_w  [$];
  int   exp_b  [$];
  aw_t  pend_aw [NREQ];
  int   pend_nresp [NREQ];
  w_t   pend_w [NREQ][$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: actual=timeout required=handshake", nm);
  endtask

  // Requester-side stimulus: fields, beat list and wlast (optionally corrupted at beat inj).
  task automatic make_req(input int i, input int len, input int nib, input int inj);
    aw_t a;
    w_t  w;
    int  beats;
    a.g = i; a.addr = 10'($urandom); a.len = 8'(len); a.size = 3'($urandom);
    a.burst = 2'($urandom); a.str = 3'($urandom); a.num = {4'($urandom), 4'(nib)};
    a.oram = 13'($urandom);
    pend_aw[i] = a;
    pend_nresp[i] = nib + 1;
    beats = (nib + 1) * (len + 1);
    pend_w[i].delete();
    for (int b = 0; b < beats; b++) begin
      w.g = i; w.data = {$urandom, $urandom}; w.strb = 8'($urandom);
      w.last = (b == beats - 1);
      if (b == inj) begin
        w.last = ~w.last;
        m_err_wlast = 1'b1;
      end
      pend_w[i].push_back(w);
    end
  endtask

  // Reference model: requesters in mask are served round-robin from m_rr, each
  // burst is contiguous, and responses come back in grant order.
  task automatic plan(input logic [NREQ-1:0] mask, output int nresp);
    logic [NREQ-1:0] p;
    int g;
    p = mask;
    nresp = 0;
    while (p != '0) begin
      g = m_rr;
      while (!p[g]) g = (g + 1) % NREQ;
      exp_aw.push_back(pend_aw[g]);
      for (int b = 0; b < pend_w[g].size(); b++) exp_w.push_back(pend_w[g][b]);
      repeat (pend_nresp[g]) exp_b.push_back(g);
      nresp += pend_nresp[g];
      p[g] = 1'b0;
      m_rr = (g + 1) % NREQ;
    end
  endtask

  task automatic drive(input int i, input logic [NREQ-1:0] mask);
    int cyc;
    w_t w;
    if (!mask[i]) return;
    aw_r[i] = pend_aw[i];
    awvld_r[i] = 1'b1;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (abort) begin awvld_r[i] = 1'b0; return; end
      if (req_awrdy[i]) break;
      if (++cyc > 3000) begin fail_now($sformatf("aw_wait_r%0d", i)); awvld_r[i] = 1'b0; return; end
    end
    @(posedge clk); #1;
    awvld_r[i] = 1'b0;
    while (pend_w[i].size() > 0) begin
      w = pend_w[i].pop_front();
      w_r[i] = w;
      wvld_r[i] = 1'b1;
      cyc = 0;
      forever begin
        @(negedge clk);
        if (abort) begin wvld_r[i] = 1'b0; return; end
        if (req_wrdy[i]) break;
        if (++cyc > 3000) begin fail_now($sformatf("w_wait_r%0d", i)); wvld_r[i] = 1'b0; return; end
      end
      @(posedge clk); #1;
    end
    wvld_r[i] = 1'b0;
  endtask

  task automatic send_resps(input int n, input bit chk_busy);
    int cyc;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      axi_lsu_bvld = 1'b1;
      axi_lsu_bresp = 2'($urandom);
      axi_lsu_resp_oram_addr = 13'($urandom);
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!lsu_axi_brdy && cyc < 500);
      if (!lsu_axi_brdy) begin
        fail_now("b_wait");
        axi_lsu_bvld = 1'b0;
        return;
      end
      @(posedge clk); #1;
      axi_lsu_bvld = 1'b0;
      if (chk_busy) begin
        @(negedge clk);
        chk("busy_after_b", 64'(arb_busy), 64'(exp_b.size() != 0));
      end
    end
  endtask

  task automatic run_phase(input logic [NREQ-1:0] mask);
    int n;
    @(posedge clk); #1;
    plan(mask, n);
    for (int i = 0; i < NREQ; i++) begin
      automatic int ii = i;
      fork drive(ii, mask); join_none
    end
    wait fork;
    send_resps(n, 1'b1);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      axi_lsu_awrdy = ($urandom % 4) != 0;
      axi_lsu_wrdy  = ($urandom % 4) != 0;
      for (int i = 0; i < NREQ; i++) brdy_r[i] = ($urandom % 3) != 0;
    end
  end

  // Monitors: pop the expected item whenever the DUT completes a handshake.
  initial begin
    aw_t e;
    w_t  w;
    int  g;
    forever begin
      @(negedge clk);
      if (!rst && lsu_axi_awvld && axi_lsu_awrdy) begin
        if (exp_aw.size() == 0) fail_now("aw_unexpected");
        else begin
          e = exp_aw.pop_front();
          chk("aw_addr", 64'(lsu_axi_awaddr), 64'(e.addr));
          chk("aw_len", 64'(lsu_axi_awlen), 64'(e.len));
          chk("aw_size_burst_str", 64'({lsu_axi_awsize, lsu_axi_awburst, lsu_axi_awstr}),
              64'({e.size, e.burst, e.str}));
          chk("aw_num", 64'(lsu_axi_awnum), 64'(e.num));
          chk("aw_oram", 64'(lsu_axi_oram_addr), 64'(e.oram));
          chk("aw_rdy_route", 64'(req_awrdy), 64'(1 << e.g));
        end
      end
      if (!rst && lsu_axi_wvld && axi_lsu_wrdy) begin
        if (exp_w.size() == 0) fail_now("w_unexpected");
        else begin
          w = exp_w.pop_front();
          chk("w_data", lsu_axi_wdata, w.data);
          chk("w_strb_last", 64'({lsu_axi_wstrb, lsu_axi_wlast}), 64'({w.strb, w.last}));
          chk("w_rdy_route", 64'(req_wrdy), 64'(1 << w.g));
        end
      end
      if (!rst && axi_lsu_bvld) begin
        if (exp_b.size() == 0) begin
          chk("orphan_brdy", 64'(lsu_axi_brdy), 64'(0));
          chk("orphan_bvld", 64'(req_bvld), 64'(0));
        end else begin
          g = exp_b[0];
          chk("b_vld_route", 64'(req_bvld), 64'(1 << g));
          chk("b_rdy_route", 64'(lsu_axi_brdy), 64'(brdy_r[g]));
          chk("b_payload", 64'({req_bresp, req_resp_oram_addr}),
              64'({axi_lsu_bresp, axi_lsu_resp_oram_addr}));
          if (lsu_axi_brdy) void'(exp_b.pop_front());
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n, cyc, len, nib, beats;
    logic [NREQ-1:0] mask;
    logic seen;
    for (int i = 0; i < NREQ; i++) begin
      awvld_r[i] = 1'b0; wvld_r[i] = 1'b0; brdy_r[i] = 1'b0;
    end
    axi_lsu_bresp = '0;
    axi_lsu_resp_oram_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_awrdy", 64'(req_awrdy), 64'(0));
    chk("rst_wrdy", 64'(req_wrdy), 64'(0));
    chk("rst_bvld", 64'(req_bvld), 64'(0));
    chk("rst_vld_out", 64'({lsu_axi_awvld, lsu_axi_wvld, lsu_axi_brdy}), 64'(0));
    chk("rst_busy", 64'(arb_busy), 64'(0));
    chk("rst_errs", 64'({err_wlast, err_orphan_b}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    make_req(0, 3, 0, -1);
    run_phase(2'b01);

    for (int r = 0; r < 4; r++) begin
      make_req(0, $urandom % 4, 0, -1);
      make_req(1, $urandom % 4, 0, -1);
      run_phase(2'b11);
    end

    make_req(1, 1, 2, -1);
    run_phase(2'b10);
    chk("err_wlast_clean", 64'(err_wlast), 64'(m_err_wlast));

    // Fill the tag FIFO, then a fifth request must wait for one retirement.
    for (int r = 0; r < OST_DEPTH; r++) begin
      make_req(0, $urandom % 2, 0, -1);
      @(posedge clk); #1;
      plan(2'b01, n);
      drive(0, 2'b01);
    end
    make_req(1, 1, 0, -1);
    @(posedge clk); #1;
    plan(2'b10, n);
    fork drive(1, 2'b10); join_none
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | lsu_axi_awvld;
    end
    chk("full_no_grant", 64'(seen), 64'(0));
    chk("full_busy", 64'(arb_busy), 64'(1));
    chk("full_aw_pending", 64'(exp_aw.size()), 64'(1));
    send_resps(1, 1'b1);
    wait fork;
    chk("full_granted_after_pop", 64'(exp_aw.size()), 64'(0));
    send_resps(OST_DEPTH, 1'b1);

    make_req(0, 3, 0, 1);
    run_phase(2'b01);
    chk("err_wlast_set", 64'(err_wlast), 64'(1));

    for (int r = 0; r < 8; r++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        len = $urandom % 4;
        nib = $urandom % 3;
        beats = (len + 1) * (nib + 1);
        if (mask[i]) make_req(i, len, nib, (($urandom % 4) == 0) ? int'($urandom % beats) : -1);
      end
      run_phase(mask);
    end
    chk("err_wlast_model", 64'(err_wlast), 64'(m_err_wlast));

    chk("orphan_before", 64'(err_orphan_b), 64'(0));
    @(posedge clk); #1;
    axi_lsu_bvld = 1'b1;
    @(negedge clk);
    chk("orphan_brdy_direct", 64'(lsu_axi_brdy), 64'(0));
    @(posedge clk); #1;
    axi_lsu_bvld = 1'b0;
    @(negedge clk);
    chk("orphan_flag", 64'(err_orphan_b), 64'(1));
    chk("orphan_idle", 64'(arb_busy), 64'(0));

    // Abort a long burst mid-data with reset.
    make_req(0, 15, 3, -1);
    @(posedge clk); #1;
    plan(2'b01, n);
    fork drive(0, 2'b01); join_none
    cyc = 0;
    while (exp_w.size() > 60 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_in_data", 64'(exp_w.size() <= 60), 64'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    abort = 1'b1;
    #1;
    chk("abort_wr_out", 64'({lsu_axi_wvld, req_wrdy}), 64'(0));
    chk("abort_aw_out", 64'({lsu_axi_awvld, req_awrdy}), 64'(0));
    chk("abort_b_out", 64'({req_bvld, lsu_axi_brdy}), 64'(0));
    chk("abort_busy", 64'(arb_busy), 64'(0));
    chk("abort_errs", 64'({err_wlast, err_orphan_b}), 64'(0));
    wait fork;
    exp_aw.delete(); exp_w.delete(); exp_b.delete();
    for (int i = 0; i < NREQ; i++) begin
      pend_w[i].delete();
      awvld_r[i] = 1'b0;
      wvld_r[i] = 1'b0;
    end
    m_rr = 0;
    m_err_wlast = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b0;
    rst = 1'b0;

    make_req(0, $urandom % 4, $urandom % 3, -1);
    make_req(1, $urandom % 4, $urandom % 3, -1);
    run_phase(2'b11);
    chk("post_rst_errs", 64'({err_wlast, err_orphan_b}), 64'(0));

    chk("end_aw_drained", 64'(exp_aw.size()), 64'(0));
    chk("end_w_drained", 64'(exp_w.size()), 64'(0));
    chk("end_b_drained", 64'(exp_b.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
